// File: rtl/lab2_tx_pkg.sv
// Shared types and constants for the Lab2 result transmitter.
package lab2_tx_pkg;

  localparam int unsigned SUM_W   = 4;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned STATE_W = 3;

  localparam logic [STATE_W-1:0] S_IDLE   = 3'd0;
  localparam logic [STATE_W-1:0] S_PREFIX = 3'd1;
  localparam logic [STATE_W-1:0] S_CARRY  = 3'd2;
  localparam logic [STATE_W-1:0] S_SUM    = 3'd3;
  localparam logic [STATE_W-1:0] S_CR     = 3'd4;
  localparam logic [STATE_W-1:0] S_LF     = 3'd5;

  localparam logic [BYTE_W-1:0] ASCII_0  = 8'h30;
  localparam logic [BYTE_W-1:0] ASCII_A  = 8'h41;
  localparam logic [BYTE_W-1:0] ASCII_CR = 8'h0D;
  localparam logic [BYTE_W-1:0] ASCII_LF = 8'h0A;

  typedef struct packed {
    logic             sub;
    logic             cout;
    logic [SUM_W-1:0] sum;
  } result_t;

endpackage

// File: rtl/nibble_to_ascii.sv
// Combinational 4-bit value to uppercase ASCII hex digit.
module nibble_to_ascii
  import lab2_tx_pkg::*;
(
  input  logic [SUM_W-1:0]  nibble,
  output logic [BYTE_W-1:0] ascii_c
);

  always_comb begin
    if (nibble < SUM_W'(10)) ascii_c = ASCII_0 + BYTE_W'(nibble);
    else                     ascii_c = ASCII_A + BYTE_W'(nibble - SUM_W'(10));
  end

endmodule

// File: rtl/lab2_result_tx.sv
// Captures adder results on the i_rdy rising edge and streams each one
// to the UART TX as an ASCII line: prefix, [carry], hex sum, CR, [LF].
module lab2_result_tx
  import lab2_tx_pkg::*;
#(
  parameter logic [BYTE_W-1:0] PREFIX_CHAR = 8'h3D,
  parameter bit                SEND_LF     = 1'b1
) (
  input  logic              i_clk_in,
  input  logic              i_rst,
  input  logic              i_rdy,
  input  logic [SUM_W-1:0]  i_sum,
  input  logic              i_cout,
  input  logic              i_sub,
  output logic [BYTE_W-1:0] o_tx_data,
  output logic              o_tx_valid,
  input  logic              i_tx_ready,
  output logic              o_busy,
  output logic              o_overrun,
  output logic [7:0]        o_lines
);

  logic [STATE_W-1:0] state_q, state_n;
  result_t            act_q, act_n, pend_q, pend_n, cap_res;
  logic               pend_full_q, pend_full_n;
  logic               rdy_d, cap, take, accept;
  logic               overrun_n, valid_n, busy_n;
  logic [BYTE_W-1:0]  data_n, sum_char_c;
  logic [7:0]         lines_n;

  assign cap     = i_rdy & ~rdy_d;
  assign cap_res = '{sub: i_sub, cout: i_cout, sum: i_sum};
  assign accept  = o_tx_valid & i_tx_ready;

  // SUM is only ever entered mid-line, so the active register is already stable
  nibble_to_ascii u_hex (
    .nibble  (act_q.sum),
    .ascii_c (sum_char_c)
  );

  always_comb begin
    state_n     = state_q;
    act_n       = act_q;
    pend_n      = pend_q;
    pend_full_n = pend_full_q;
    overrun_n   = o_overrun;
    lines_n     = o_lines;
    take        = 1'b0;
    data_n      = o_tx_data;

    case (state_q)
      S_IDLE: begin
        if (pend_full_q) begin
          take    = 1'b1;
          act_n   = pend_q;
          state_n = S_PREFIX;
        end
      end
      S_PREFIX: if (accept) state_n = act_q.sub ? S_SUM : S_CARRY;
      S_CARRY:  if (accept) state_n = S_SUM;
      S_SUM:    if (accept) state_n = S_CR;
      S_CR: begin
        if (accept) begin
          if (SEND_LF) begin
            state_n = S_LF;
          end else begin
            state_n = S_IDLE;
            lines_n = o_lines + 8'd1;
          end
        end
      end
      S_LF: begin
        if (accept) begin
          state_n = S_IDLE;
          lines_n = o_lines + 8'd1;
        end
      end
      default: state_n = S_IDLE;
    endcase

    // A capture landing while the slot is being drained refills it cleanly
    if (cap) begin
      if (!pend_full_q || take) begin
        pend_n      = cap_res;
        pend_full_n = 1'b1;
      end else begin
        overrun_n = 1'b1;
      end
    end else if (take) begin
      pend_full_n = 1'b0;
    end

    case (state_n)
      S_PREFIX: data_n = PREFIX_CHAR;
      S_CARRY:  data_n = ASCII_0 + BYTE_W'(act_q.cout);
      S_SUM:    data_n = sum_char_c;
      S_CR:     data_n = ASCII_CR;
      S_LF:     data_n = ASCII_LF;
      default:  data_n = o_tx_data;
    endcase

    valid_n = (state_n != S_IDLE);
    busy_n  = valid_n | pend_full_n;
  end

  always_ff @(posedge i_clk_in or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      act_q       <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      rdy_d       <= 1'b0;
      o_tx_valid  <= 1'b0;
      o_tx_data   <= '0;
      o_busy      <= 1'b0;
      o_overrun   <= 1'b0;
      o_lines     <= '0;
    end else begin
      state_q     <= state_n;
      act_q       <= act_n;
      pend_q      <= pend_n;
      pend_full_q <= pend_full_n;
      rdy_d       <= i_rdy;
      o_tx_valid  <= valid_n;
      o_tx_data   <= data_n;
      o_busy      <= busy_n;
      o_overrun   <= overrun_n;
      o_lines     <= lines_n;
    end
  end

endmodule
